// File: rtl/cb_crc32_arb.sv
// cb_crc32_arb: frame-level round-robin scheduler sharing one cb_crc32 byte engine between REQ_NUM requesters.
// Build macro CB_CRC32_ARB_FINAL_XOR_EN: when defined, res_crc carries the final inversion (~crc_data).
//
// state | meaning
// IDLE  | no frame owned; picks the next valid requester round-robin from rr_ptr
// CLEAR | one-cycle crc_clear to the engine, byte count reset
// FEED  | granted requester streams bytes, one engine strobe per accepted byte
// WAIT  | last byte sent, waiting for the engine result that belongs to it
// DONE  | result presented until res_ready, then rr_ptr moves past the owner
module cb_crc32_arb #(
    parameter int U_DLY   = 1,
    parameter int REQ_NUM = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk_sys,
    input  logic                 rst,
    input  logic [8*REQ_NUM-1:0] req_data,
    input  logic [REQ_NUM-1:0]   req_valid,
    input  logic [REQ_NUM-1:0]   req_last,
    output logic [REQ_NUM-1:0]   req_ready,
    output logic                 crc_clear,
    output logic [7:0]           src_data,
    output logic                 src_data_valid,
    input  logic [31:0]          crc_data,
    input  logic                 crc_data_valid,
    output logic [31:0]          res_crc,
    output logic [ID_W-1:0]      res_id,
    output logic [15:0]          res_len,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 busy
);

    // U_DLY is a simulation-only parameter kept for port compatibility; no delays are modelled here.
    if (U_DLY < 0 || REQ_NUM < 2 || REQ_NUM > 8 || ID_W != $clog2(REQ_NUM)) begin : g_param_chk
        $error("cb_crc32_arb: inconsistent U_DLY/REQ_NUM/ID_W");
    end

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      grant;
    logic [ID_W-1:0]      grant_inc;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      pick_id;
    logic                 pick_found;
    logic [7:0]           grant_byte;
    logic                 grant_valid;
    logic                 grant_last;
    logic [REQ_NUM-1:0]   grant_onehot;
    logic                 fire;
    logic [15:0]          len_cnt;
    logic                 wait_arm;
    logic [31:0]          crc_final;

    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int k = 0; k < REQ_NUM; k++) begin
            for (int j = 0; j < REQ_NUM; j++) begin
                if (!pick_found && req_valid[j] && (j == (int'(rr_ptr) + k) % REQ_NUM)) begin
                    pick_found = 1'b1;
                    pick_id    = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        grant_byte   = 8'h00;
        grant_valid  = 1'b0;
        grant_last   = 1'b0;
        grant_onehot = '0;
        for (int i = 0; i < REQ_NUM; i++) begin
            if (int'(grant) == i) begin
                grant_byte      = req_data[8*i +: 8];
                grant_valid     = req_valid[i];
                grant_last      = req_last[i];
                grant_onehot[i] = 1'b1;
            end
        end
    end

    assign grant_inc = (int'(grant) == REQ_NUM - 1) ? '0 : grant + 1'b1;
    assign fire      = (state == ST_FEED) && grant_valid;
    assign busy      = (state != ST_IDLE);

`ifdef CB_CRC32_ARB_FINAL_XOR_EN
    assign crc_final = ~crc_data;
`else
    assign crc_final = crc_data;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (pick_found) state_nxt = ST_CLEAR;
            ST_CLEAR: state_nxt = ST_FEED;
            ST_FEED:  if (fire && grant_last) state_nxt = ST_WAIT;
            ST_WAIT:  if (wait_arm && crc_data_valid) state_nxt = ST_DONE;
            ST_DONE:  if (res_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            grant          <= '0;
            rr_ptr         <= '0;
            req_ready      <= '0;
            crc_clear      <= 1'b0;
            src_data       <= 8'h00;
            src_data_valid <= 1'b0;
            len_cnt        <= 16'h0000;
            wait_arm       <= 1'b0;
            res_crc        <= 32'h0;
            res_id         <= '0;
            res_len        <= 16'h0000;
            res_valid      <= 1'b0;
        end else begin
            crc_clear      <= (state_nxt == ST_CLEAR);
            req_ready      <= (state_nxt == ST_FEED) ? grant_onehot : '0;
            src_data_valid <= fire;
            if (fire) begin
                src_data <= grant_byte;
            end
            if (state == ST_IDLE && pick_found) begin
                grant <= pick_id;
            end
            if (state == ST_CLEAR) begin
                len_cnt <= 16'h0000;
            end else if (fire && len_cnt != 16'hFFFF) begin
                len_cnt <= len_cnt + 16'd1;
            end
            // The first WAIT cycle may still see the result of the byte before the last one.
            wait_arm <= (state == ST_WAIT) && (state_nxt == ST_WAIT);
            if (state == ST_WAIT && state_nxt == ST_DONE) begin
                res_crc   <= crc_final;
                res_id    <= grant;
                res_len   <= len_cnt;
                res_valid <= 1'b1;
            end else if (state == ST_DONE && res_ready) begin
                res_valid <= 1'b0;
                rr_ptr    <= grant_inc;
            end
        end
    end

endmodule
